// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter: byte FIFO feeding an 8N1 / 8E1 serialiser
module uart_tx #(
  parameter real CLK_FREQUENCY = 102.1e6,
  parameter int  BAUD_RATE     = 115200,
  parameter int  IF_PARITY     = 0,
  parameter int  FIFO_DEPTH    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       uart_tx_o
);

  // Truncated division so bit timing matches the receiver exactly.
  localparam int CPB  = $rtoi(CLK_FREQUENCY / BAUD_RATE);
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   baud_cnt;
  logic            baud_wrap;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_q;
  logic            tx_q;
  logic            tx_d;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
  // A write against a full FIFO is lost even if a pop frees a slot this cycle.
  assign push       = wr_i && !fifo_full;
  assign head       = mem[rd_ptr];
  assign baud_wrap  = (baud_cnt == CW'(CPB - 1));

  assign full_o    = fifo_full;
  assign busy_o    = (state_q != S_IDLE) || !fifo_empty;
  assign uart_tx_o = tx_q;

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and FIFO pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START:  if (baud_wrap) state_d = S_DATA;
      S_DATA: begin
        if (baud_wrap && bit_cnt == 3'd7)
          state_d = (IF_PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (baud_wrap) state_d = S_STOP;
      S_STOP: begin
        if (baud_wrap) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Next line value; only changes on baud wraps or when a frame starts
  always_comb begin
    tx_d = tx_q;
    case (state_q)
      S_IDLE:   tx_d = !pop;
      S_START:  if (baud_wrap) tx_d = shreg[0];
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_cnt == 3'd7) tx_d = (IF_PARITY != 0) ? par_q : 1'b1;
          else                 tx_d = shreg[1];
        end
      end
      S_PARITY: if (baud_wrap) tx_d = 1'b1;
      S_STOP:   if (baud_wrap) tx_d = !pop;
      default:  tx_d = 1'b1;
    endcase
  end

  // Baud/bit counters, shift register, parity and registered line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (state_q == S_IDLE || baud_wrap) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shreg <= head;
        par_q <= ^head;
      end else if (state_q == S_DATA && baud_wrap) begin
        shreg <= shreg >> 1;
      end
      if (state_q == S_START && baud_wrap)     bit_cnt <= '0;
      else if (state_q == S_DATA && baud_wrap) bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a behavioural line model
module tb_uart_tx;

  localparam int SLOW_CPB   = 886;          // 102.1e6 / 115200 truncated
  localparam int FAST_BAUD  = 10_000_000;
  localparam int FAST_CPB   = 10;           // 102.1e6 / 10e6 truncated
  localparam int FAST_FRAME = 11 * FAST_CPB; // parity enabled on the fast instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst, s_wr, s_full, s_busy, s_tx;
  logic [7:0] s_data;
  logic       f_rst, f_wr, f_full, f_busy, f_tx;
  logic [7:0] f_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];
  int         rx_bad = 0;

  uart_tx u_slow (
    .clk_i(clk), .rst_i(s_rst), .wr_i(s_wr), .data_i(s_data),
    .full_o(s_full), .busy_o(s_busy), .uart_tx_o(s_tx)
  );

  uart_tx #(.BAUD_RATE(FAST_BAUD), .IF_PARITY(1)) u_fast (
    .clk_i(clk), .rst_i(f_rst), .wr_i(f_wr), .data_i(f_data),
    .full_o(f_full), .busy_o(f_busy), .uart_tx_o(f_tx)
  );

  // Line value per bit slot: start, 8 data LSB-first, optional even parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
    if (par) f[9] = ^b;
    return f;
  endfunction

  // Receiver model on the fast line: mid-bit sampling, 8E1
  initial begin : rx_monitor
    logic [7:0] b;
    logic       p, st;
    forever begin
      @(negedge clk);
      if (f_rst === 1'b1 && f_tx === 1'b0) begin
        repeat (FAST_CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (FAST_CPB) @(negedge clk);
          b[k] = f_tx;
        end
        repeat (FAST_CPB) @(negedge clk);
        p = f_tx;
        repeat (FAST_CPB) @(negedge clk);
        st = f_tx;
        rx_q.push_back(b);
        if (p !== ^b || st !== 1'b1) rx_bad++;
      end
    end
  end

  task automatic test_reset();
    s_rst = 1'b0; f_rst = 1'b0;
    s_wr = 1'b0; f_wr = 1'b0; s_data = 8'h00; f_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (s_tx !== 1'b1)   begin errors++; $display("FAIL reset_slow_tx got %b exp 1", s_tx); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_slow_busy got %b exp 0", s_busy); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_slow_full got %b exp 0", s_full); end
    checks++; if (f_tx !== 1'b1)   begin errors++; $display("FAIL reset_fast_tx got %b exp 1", f_tx); end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL reset_fast_busy got %b exp 0", f_busy); end
    checks++; if (f_full !== 1'b0) begin errors++; $display("FAIL reset_fast_full got %b exp 0", f_full); end
    s_rst = 1'b1; f_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_55();
    logic [10:0] fb;
    int          bad [10];
    int          busy_bad;
    fb = frame_bits(8'h55, 1'b0);
    foreach (bad[i]) bad[i] = 0;
    busy_bad = 0;
    s_wr = 1'b1; s_data = 8'h55;
    @(negedge clk);
    s_wr = 1'b0;
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL f55_busy_after_write got %b exp 1", s_busy); end
    checks++; if (s_tx !== 1'b1)   begin errors++; $display("FAIL f55_line_before_start got %b exp 1", s_tx); end
    for (int t = 0; t < 10 * SLOW_CPB; t++) begin
      @(negedge clk);
      if (s_tx !== fb[t / SLOW_CPB]) bad[t / SLOW_CPB]++;
      if (s_busy !== 1'b1) busy_bad++;
    end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (bad[b] != 0) begin
        errors++;
        $display("FAIL f55_slot%0d wrong samples %0d exp 0 (line should be %b)", b, bad[b], fb[b]);
      end
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL f55_busy_in_frame low samples %0d exp 0", busy_bad); end
    @(negedge clk);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL f55_busy_end got %b exp 0", s_busy); end
    checks++; if (s_tx !== 1'b1)   begin errors++; $display("FAIL f55_line_end got %b exp 1", s_tx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int         tx_bad, busy_bad;
    d = 8'($urandom);
    d[3] = 1'b0;
    s_wr = 1'b1; s_data = d;
    @(negedge clk);
    s_data = 8'($urandom);
    @(negedge clk);
    s_data = 8'($urandom);
    @(negedge clk);
    s_wr = 1'b0;
    repeat (4 * SLOW_CPB + SLOW_CPB / 2 - 1) @(negedge clk);
    checks++; if (s_tx !== 1'b0)   begin errors++; $display("FAIL rst_mid_bit3 got %b exp 0", s_tx); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", s_busy); end
    #2;
    s_rst = 1'b0;
    #1;
    checks++; if (s_tx !== 1'b1)   begin errors++; $display("FAIL rst_async_tx got %b exp 1", s_tx); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", s_busy); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL rst_async_full got %b exp 0", s_full); end
    @(negedge clk);
    s_rst = 1'b1;
    tx_bad = 0; busy_bad = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (s_tx !== 1'b1) tx_bad++;
      if (s_busy !== 1'b0) busy_bad++;
    end
    checks++; if (tx_bad != 0)   begin errors++; $display("FAIL rst_after_line non-idle samples %0d exp 0", tx_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL rst_after_busy busy samples %0d exp 0", busy_bad); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL rst_after_full got %b exp 0", s_full); end
  endtask

  task automatic test_parity_back_to_back();
    logic [10:0] fa, fb, e;
    int          bad [22];
    logic        p1, p2;
    fa = frame_bits(8'h07, 1'b1);
    fb = frame_bits(8'h03, 1'b1);
    foreach (bad[i]) bad[i] = 0;
    p1 = 1'bx; p2 = 1'bx;
    rx_q.delete();
    f_wr = 1'b1; f_data = 8'h07;
    @(negedge clk);
    f_data = 8'h03;
    @(negedge clk);
    f_wr = 1'b0;
    for (int t = 0; t < 2 * FAST_FRAME; t++) begin
      e = (t < FAST_FRAME) ? fa : fb;
      if (f_tx !== e[(t % FAST_FRAME) / FAST_CPB]) bad[(t / FAST_FRAME) * 11 + (t % FAST_FRAME) / FAST_CPB]++;
      if (t == 9 * FAST_CPB + FAST_CPB / 2) p1 = f_tx;
      if (t == FAST_FRAME + 9 * FAST_CPB + FAST_CPB / 2) p2 = f_tx;
      @(negedge clk);
    end
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (bad[i] != 0) begin
        errors++;
        $display("FAIL par_frame%0d_slot%0d wrong samples %0d exp 0", i / 11, i % 11, bad[i]);
      end
    end
    checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL par_bit_07 got %b exp 1", p1); end
    checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL par_bit_03 got %b exp 0", p2); end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL par_busy_end got %b exp 0", f_busy); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL par_rx_count got %0d exp 2", rx_q.size()); end
  endtask

  task automatic test_fill_and_overflow();
    logic [7:0] exp_q [$];
    int         free_n, first_free, w;
    rx_q.delete();
    for (int i = 0; i < 17; i++) begin
      f_wr = 1'b1; f_data = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge clk);
      if (i == 15) begin
        checks++; if (f_full !== 1'b0) begin errors++; $display("FAIL fill_16_writes full got %b exp 0", f_full); end
      end
    end
    checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL fill_17_writes full got %b exp 1", f_full); end
    f_data = 8'hAA;
    free_n = 0; first_free = -1;
    for (int c = 1; c <= 340; c++) begin
      @(negedge clk);
      if (f_full === 1'b0) begin
        free_n++;
        if (first_free < 0) first_free = c;
      end
    end
    f_wr = 1'b0;
    repeat (3) exp_q.push_back(8'hAA);
    checks++; if (free_n != 3) begin errors++; $display("FAIL ovf_free_cycles got %0d exp 3", free_n); end
    checks++;
    if (first_free != FAST_FRAME - 15) begin
      errors++; $display("FAIL ovf_first_free got %0d exp %0d", first_free, FAST_FRAME - 15);
    end
    w = 0;
    while (rx_q.size() < exp_q.size() && w < 4000) begin @(negedge clk); w++; end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fill_rx_count got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fill_rx_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (FAST_CPB) @(negedge clk);
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end got %b exp 0", f_busy); end
    checks++; if (f_full !== 1'b0) begin errors++; $display("FAIL fill_full_end got %b exp 0", f_full); end
  endtask

  task automatic test_random_loopback();
    logic [7:0] sent [$];
    logic [7:0] b;
    int         w, stalled, mism;
    rx_q.delete();
    stalled = 0;
    for (int n = 0; n < 256 && stalled == 0; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 0;
      while (f_full === 1'b1 && w < 2000) begin @(negedge clk); w++; end
      if (w >= 2000) stalled = 1;
      else begin
        b = 8'($urandom);
        f_wr = 1'b1; f_data = b;
        @(negedge clk);
        f_wr = 1'b0;
        sent.push_back(b);
      end
    end
    checks++; if (stalled != 0) begin errors++; $display("FAIL rand_full_stuck got stalled exp free"); end
    w = 0;
    while (rx_q.size() < sent.size() && w < 40000) begin @(negedge clk); w++; end
    checks++;
    if (rx_q.size() != sent.size()) begin
      errors++; $display("FAIL rand_rx_count got %0d exp %0d", rx_q.size(), sent.size());
    end
    mism = 0;
    for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== sent[i]) begin
        errors++; mism++;
        if (mism <= 8) $display("FAIL rand_rx_byte%0d got %h exp %h", i, rx_q[i], sent[i]);
      end
    end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL rand_frame_errors got %0d exp 0", rx_bad); end
    repeat (FAST_CPB) @(negedge clk);
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL rand_busy_end got %b exp 0", f_busy); end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_reset_mid_frame();
    test_parity_back_to_back();
    test_fill_and_overflow();
    test_random_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, the transmit-side counterpart of the design's UART receiver. Accepts bytes from on-chip logic into a small FIFO and serialises each one onto the TX line as start bit, 8 data bits LSB-first, an optional even-parity bit, and one stop bit. Runs in the 102.1 MHz system clock domain and uses the same integer-truncated baud division as the receiver, so both ends of the link agree on bit timing.

## Interface
- `CLK_FREQUENCY`, 102.1e6: system clock in Hz; fixed for this design.
- `BAUD_RATE`, 115200: line rate. `CPB = CLK_FREQUENCY/BAUD_RATE`, truncated; default gives 886.
- `IF_PARITY`, 0: 0 = no parity bit; 1 = even-parity bit after the data.
- `FIFO_DEPTH`, 16: byte FIFO depth; power of two, 2 to 256.
- `clk_i` input, 1 bit: system clock, all logic on the rising edge.
- `rst_i` input, 1 bit: reset; one clock, asynchronous, active-low.
- `wr_i` input, 1 bit: write strobe; pushes `data_i` when `full_o`=0.
- `data_i` input, 8 bits: byte to transmit.
- `full_o` output, 1 bit: FIFO holds `FIFO_DEPTH` bytes.
- `busy_o` output, 1 bit: 1 while a frame is on the line or the FIFO is non-empty.
- `uart_tx_o` output, 1 bit: serial line, registered, idles high.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of log2(`FIFO_DEPTH`)+1 bits; pointers wrap modulo `FIFO_DEPTH`.
  - `full_o` and `busy_o` are decoded from registered state only, with no combinational path from `wr_i`.
  - A write while `full_o`=1 is dropped, even if a pop happens in the same cycle. Dropped writes are not flagged.
  - Write and pop in the same cycle while not full: count unchanged, both pointers advance.
- FSM states:
  - IDLE: line high. When the FIFO is non-empty, pop the head into the shift register, clear the baud counter, drive the line low, go to START.
  - START: after `CPB` clocks, drive the LSB, go to DATA.
  - DATA: each bit is held `CPB` clocks, then the register shifts right. After bit 7, go to PARITY if `IF_PARITY`, otherwise to STOP.
  - PARITY: drive the XOR of the 8 data bits for `CPB` clocks, then go to STOP.
  - STOP: drive high for `CPB` clocks. At the end, if the FIFO is non-empty, pop and go straight to START with the line low on that edge (no idle gap). Otherwise go to IDLE.
- Counters:
  - Baud counter runs 0..`CPB`-1 and wraps; it is held at 0 in IDLE.
  - Bit counter is 3 bits and resets on entry to DATA.
- The line value is registered, so transitions occur only on baud-counter wrap edges or on the IDLE->START edge.

## Timing
- Reset values: `uart_tx_o`=1, `busy_o`=0, `full_o`=0, FSM in IDLE, FIFO empty, all counters 0.
- Asserting `rst_i` mid-frame forces the line high immediately (asynchronously) and discards the frame and the FIFO contents.
- Latency, idle and empty: a byte written at edge E leaves IDLE at edge E+1, so `uart_tx_o` falls after E+1 and `busy_o` is 1 after E.
- Every bit period is exactly `CPB` clocks. A frame is 10·`CPB` clocks (11·`CPB` with parity), i.e. 8860 clocks at the defaults.
- Back-to-back frames: stop bit end to next start bit is 0 clocks.
- `busy_o` falls on the edge where STOP ends with the FIFO empty.
- `full_o` rises the clock after the write that fills the FIFO. It falls the clock after the first pop from a full FIFO.

## Test plan
- Reset, then write 0x55 once:
  - Line low for 886 clocks, then bits 1,0,1,0,1,0,1,0 at 886 clocks each, then high for 886.
  - `busy_o` drops 8860 clocks after the line falls.
- `IF_PARITY`=1, write 0x07 then 0x03:
  - Parity bits 1 then 0.
  - Frames are 9746 clocks each with no gap between them.
- Write 17 bytes 0x00..0x10 in consecutive cycles with the FIFO idle:
  - `full_o` rises after the 17th write, because one byte was already popped.
  - All 17 bytes are transmitted in order.
- With the FIFO full, hold `wr_i` with 0xAA:
  - No bytes are accepted until `full_o` falls.
  - Exactly one 0xAA is stored per freed slot.
- Assert `rst_i` in the middle of data bit 3:
  - `uart_tx_o`=1 with no clock edge.
  - After release the line stays idle, `busy_o`=0 and `full_o`=0.
- Loop `uart_tx_o` into the existing receiver and send 256 random bytes:
  - The received sequence equals the sent sequence.
